// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Brief    : Arbitrates an instruction-fetch port and a load/store port onto
//             one shared single-port memory. Round-robin on contention, one
//             transaction at a time, with a wait-counter timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        iReq,
    input  logic [31:0] iAddr,
    output logic [31:0] iRdata,
    output logic        iAck,
    input  logic        dReq,
    input  logic        dWe,
    input  logic [31:0] dAddr,
    input  logic [31:0] dWdata,
    input  logic [3:0]  dStrobe,
    output logic [31:0] dRdata,
    output logic        dAck,
    output logic        err,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    output logic [3:0]  memStrobe,
    input  logic        memReady,
    input  logic [31:0] memRdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [3:0] C_WAIT_MAX = 4'd15;

    state_t      r_state;
    state_t      w_next;
    logic        w_pick_d;      // IDLE arbitration result: 1 = data side wins
    logic        r_last_grant;  // 1 = data side was granted last, 0 = fetch
    logic [3:0]  r_wait;
    logic        r_timeout;
    logic [31:0] r_addr;
    logic        r_we;
    logic [31:0] r_wdata;
    logic [3:0]  r_strobe;
    logic [31:0] r_irdata;
    logic [31:0] r_drdata;

    // Next-state and arbitration decision; RESP never grants, it always
    // drops back to IDLE so a held request is re-arbitrated fairly.
    always_comb begin
        w_next   = r_state;
        w_pick_d = 1'b0;
        case (r_state)
            IDLE: begin
                // On contention the side not served last wins.
                w_pick_d = dReq && (!iReq || !r_last_grant);
                if (iReq || dReq) begin
                    w_next = w_pick_d ? GRANT_D : GRANT_I;
                end
            end
            GRANT_I, GRANT_D: begin
                if (memReady || (r_wait == C_WAIT_MAX)) begin
                    w_next = RESP;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register, request latching, wait counter and read-data capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b0;
            r_wait       <= 4'd0;
            r_timeout    <= 1'b0;
            r_addr       <= 32'd0;
            r_we         <= 1'b0;
            r_wdata      <= 32'd0;
            r_strobe     <= 4'd0;
            r_irdata     <= 32'd0;
            r_drdata     <= 32'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (w_next != IDLE) begin
                        r_last_grant <= w_pick_d;
                        r_wait       <= 4'd0;
                        r_timeout    <= 1'b0;
                        r_addr       <= w_pick_d ? dAddr : iAddr;
                        if (w_pick_d) begin
                            r_we     <= dWe;
                            r_wdata  <= dWdata;
                            r_strobe <= dStrobe;
                        end
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (memReady) begin
                        // Stores complete without touching dRdata.
                        if (r_state == GRANT_I) begin
                            r_irdata <= memRdata;
                        end else if (!r_we) begin
                            r_drdata <= memRdata;
                        end
                    end else if (r_wait == C_WAIT_MAX) begin
                        r_timeout <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory side is driven only while a grant is active; address and write
    // data come from the latched copy so they stay stable if the requester
    // changes its inputs mid-transaction.
    assign memReq    = (r_state == GRANT_I) || (r_state == GRANT_D);
    assign memWe     = (r_state == GRANT_D) && r_we;
    assign memStrobe = (r_state == GRANT_I) ? 4'hF :
                       (r_state == GRANT_D) ? r_strobe : 4'h0;
    assign memAddr   = r_addr;
    assign memWdata  = r_wdata;

    // Completion pulses go to whichever side holds the current grant.
    assign iAck   = (r_state == RESP) && !r_last_grant;
    assign dAck   = (r_state == RESP) &&  r_last_grant;
    assign err    = (r_state == RESP) &&  r_timeout;
    assign iRdata = r_irdata;
    assign dRdata = r_drdata;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
  clk  in  1  sole clock; all state updates on rising edge.
  reset  in  1  synchronous, active-high reset.
  iReq  in  1  instruction-fetch request; held until iAck or iErr.
  iAddr  in  32  fetch byte address.
  iRdata  out  32  fetched word.
  iAck  out  1  one-cycle fetch completion pulse.
  dReq  in  1  load/store request; held until dAck or dErr.
  dWe  in  1  1 = store, 0 = load.
  dAddr  in  32  data byte address.
  dWdata  in  32  store data.
  dStrobe  in  4  store byte enables.
  dRdata  out  32  load data.
  dAck  out  1  one-cycle data completion pulse.
  err  out  1  qualifies iAck/dAck: transaction timed out.
  memReq  out  1  shared single-port memory request.
  memWe  out  1  memory write enable.
  memAddr  out  32  memory address.
  memWdata  out  32  memory write data.
  memStrobe  out  4  memory byte enables.
  memReady  in  1  memory completion; may be asserted on any cycle memReq is high.
  memRdata  in  32  memory read data, valid when memReady=1.

Function
REQ-002 The FSM SHALL have states IDLE, GRANT_I, GRANT_D and RESP, encoded in 2 bits.
REQ-003 In IDLE, dReq=1 and iReq=0 SHALL go to GRANT_D, and iReq=1 and dReq=0 SHALL go to GRANT_I.
REQ-004 In IDLE with both requests high, the requester not granted last (lastGrant register) SHALL win.
REQ-005 lastGrant SHALL update to the winner on every IDLE-to-GRANT transition.
REQ-006 On an IDLE-to-GRANT transition, the winner's address, and for data also dWe, dWdata and dStrobe, SHALL be latched.
REQ-007 In GRANT_I/GRANT_D, memReq SHALL be 1 and mem* SHALL drive latched values, stable until completion.
REQ-008 In GRANT_I, memWe SHALL be 0 and memStrobe 4'b1111.
REQ-009 In IDLE and RESP, memReq, memWe and memStrobe SHALL be 0.
REQ-010 memReady=1 in a GRANT state SHALL go to RESP.
REQ-011 On that memReady edge, memRdata SHALL be captured into iRdata (fetch) or dRdata (load).
REQ-012 A store SHALL leave dRdata unchanged.
REQ-013 In RESP, exactly the granted side's ack SHALL be 1 for one cycle, and the next state SHALL be IDLE.
REQ-014 No new grant SHALL be made from RESP.
REQ-015 Minimum latency SHALL be 3 cycles: request seen in IDLE at cycle 0, memReq at cycle 1, memReady at cycle 1, ack at cycle 2.
REQ-016 A 4-bit wait counter SHALL clear on entry to a GRANT state and increment each GRANT cycle without memReady.
REQ-017 When the wait counter reaches 15 without memReady, the FSM SHALL go to RESP with err=1 and the granted rdata output unchanged.
REQ-018 err SHALL be 0 in every cycle except a timed-out RESP.
REQ-019 memReady SHALL be ignored in IDLE and RESP.
REQ-020 Requester deassertion during GRANT SHALL not abort the transaction; the ack SHALL still issue.
REQ-021 A request held high through its ack cycle SHALL be treated as a new request in the following IDLE cycle.

Reset
REQ-022 reset=1 SHALL, on the next edge, force IDLE, lastGrant=fetch, wait counter=0, and all outputs (including iRdata/dRdata) to 0, overriding any activity.
REQ-023 Reset asserted mid-GRANT SHALL drop memReq on the next edge with no ack or err issued; memReady during reset SHALL be ignored.

Verification
REQ-024 Reset, then iReq=1 and iAddr=0x0000_0010 with memReady tied 1 and memRdata=0x0051_0093 -> memReq at cycle 1 with memAddr=0x10; iAck=1 and iRdata=0x0051_0093 at cycle 2; err=0.
REQ-025 iReq and dReq both high from reset, held (re-issued), memReady=1 -> grant order D, I, D, I; each ack spaced 3 cycles apart.
REQ-026 Store dAddr=0x100, dWdata=0xDEAD_BEEF, dStrobe=4'b0011, memReady delayed 3 cycles -> memWe=1 and memStrobe=0011 held stable 4 cycles; dAck=1 once; dRdata unchanged.
REQ-027 Load with memReady never asserted -> dAck=1 with err=1 exactly 16 cycles after the grant cycle; memReq=0 in the RESP cycle.
REQ-028 reset pulsed in the second GRANT_D cycle, memReady=1 in the same cycle -> next cycle memReq=0, dAck=0, err=0, state IDLE; a subsequent request completes normally.
